// File: rtl/frogger_game_ctrl.sv
// Frogger game-state controller: frog position, lives, score, level and
// collision checks against car and log channels, sequenced by a small FSM.
module frogger_game_ctrl #(
  parameter int unsigned c_GAME_WIDTH     = 14,
  parameter int unsigned c_GAME_HEIGHT    = 13,
  parameter int unsigned c_START_X        = 6,
  parameter int unsigned c_START_Y        = 12,
  parameter int unsigned c_GOAL_ROW       = 0,
  parameter int unsigned c_NUM_CARS       = 5,
  parameter int unsigned c_NUM_LOGS       = 5,
  parameter int unsigned c_NUM_LIVES      = 3,
  parameter int unsigned c_MAX_SCORE      = 99,
  parameter int unsigned c_GOAL_BONUS     = 10,
  parameter int unsigned c_RESPAWN_FRAMES = 60,
  parameter int unsigned c_WIN_FRAMES     = 120
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Frame_Tick,
  input  logic                      i_Game_Start,
  input  logic                      i_Up_Mvt,
  input  logic                      i_Down_Mvt,
  input  logic                      i_Left_Mvt,
  input  logic                      i_Right_Mvt,
  input  logic [6*c_NUM_CARS-1:0]   i_Car_X,
  input  logic [6*c_NUM_CARS-1:0]   i_Car_Y,
  input  logic [6*c_NUM_LOGS-1:0]   i_Log_X,
  input  logic [6*c_NUM_LOGS-1:0]   i_Log_Y,
  input  logic [3:0]                i_Tile_Type,
  output logic [5:0]                o_Frogger_X,
  output logic [5:0]                o_Frogger_Y,
  output logic [2:0]                o_Lives,
  output logic [6:0]                o_Score,
  output logic [3:0]                o_Level,
  output logic [2:0]                o_State,
  output logic                      o_Hit
);

  localparam int unsigned MAX_FRAMES = (c_RESPAWN_FRAMES > c_WIN_FRAMES) ?
                                       c_RESPAWN_FRAMES : c_WIN_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [3:0] TILE_WATER = 4'd2;
  localparam logic [3:0] TILE_LILY  = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_P1_WINS   = 3'd3,
    ST_GAME_OVER = 3'd4,
    ST_CLEANUP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       lives_q, lives_d;
  logic [6:0]       score_q, score_d;
  logic [3:0]       level_q, level_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             from_over_q, from_over_d;

  logic start_q, up_q, down_q, left_q, right_q;
  logic start_e, up_e, down_e, left_e, right_e;
  logic car_hit_c, on_log_c, hit_c, goal_c;

  // Saturating score addition
  function automatic logic [6:0] sat_add(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 8'(c_MAX_SCORE)) ? 7'(c_MAX_SCORE) : s[6:0];
  endfunction

  // Registered copies of the level inputs for rising-edge detection
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      start_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      start_q <= i_Game_Start;
      up_q    <= i_Up_Mvt;
      down_q  <= i_Down_Mvt;
      left_q  <= i_Left_Mvt;
      right_q <= i_Right_Mvt;
    end
  end

  assign start_e = i_Game_Start & ~start_q;
  assign up_e    = i_Up_Mvt     & ~up_q;
  assign down_e  = i_Down_Mvt   & ~down_q;
  assign left_e  = i_Left_Mvt   & ~left_q;
  assign right_e = i_Right_Mvt  & ~right_q;

  // Collision and goal detection against the registered frog tile
  always_comb begin
    car_hit_c = 1'b0;
    on_log_c  = 1'b0;
    for (int i = 0; i < int'(c_NUM_CARS); i++) begin
      if (i_Car_X[6*i +: 6] == x_q && i_Car_Y[6*i +: 6] == y_q) car_hit_c = 1'b1;
    end
    for (int i = 0; i < int'(c_NUM_LOGS); i++) begin
      if (i_Log_X[6*i +: 6] == x_q && i_Log_Y[6*i +: 6] == y_q) on_log_c = 1'b1;
    end
    hit_c  = car_hit_c | ((i_Tile_Type == TILE_WATER) & ~on_log_c);
    goal_c = (y_q == 6'(c_GOAL_ROW)) & (i_Tile_Type == TILE_LILY) & ~hit_c;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    lives_d     = lives_q;
    score_d     = score_q;
    level_d     = level_q;
    hit_d       = 1'b0;
    cnt_d       = '0;
    from_over_d = from_over_q;
    case (state_q)
      ST_IDLE: begin
        if (start_e) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (hit_c) begin
          hit_d   = 1'b1;
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? ST_GAME_OVER : ST_DYING;
        end else if (goal_c) begin
          score_d = sat_add(score_q, 7'(c_GOAL_BONUS));
          level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
          state_d = ST_P1_WINS;
        end else if (up_e) begin
          if (y_q != 6'd0) begin
            y_d     = y_q - 6'd1;
            score_d = sat_add(score_q, 7'd1);
          end
        end else if (down_e) begin
          if (y_q != 6'(c_GAME_HEIGHT - 1)) y_d = y_q + 6'd1;
        end else if (left_e) begin
          if (x_q != 6'd0) x_d = x_q - 6'd1;
        end else if (right_e) begin
          if (x_q != 6'(c_GAME_WIDTH - 1)) x_d = x_q + 6'd1;
        end
      end
      ST_DYING: begin
        cnt_d = cnt_q;
        if (i_Frame_Tick) begin
          if (cnt_q == CNT_W'(c_RESPAWN_FRAMES - 1)) begin
            cnt_d   = '0;
            x_d     = 6'(c_START_X);
            y_d     = 6'(c_START_Y);
            state_d = ST_RUNNING;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_P1_WINS: begin
        cnt_d = cnt_q;
        if (i_Frame_Tick) begin
          if (cnt_q == CNT_W'(c_WIN_FRAMES - 1)) begin
            cnt_d       = '0;
            from_over_d = 1'b0;
            state_d     = ST_CLEANUP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_GAME_OVER: begin
        if (start_e) begin
          from_over_d = 1'b1;
          state_d     = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        x_d = 6'(c_START_X);
        y_d = 6'(c_START_Y);
        if (from_over_q) begin
          lives_d = 3'(c_NUM_LIVES);
          score_d = 7'd0;
          level_d = 4'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 6'(c_START_X);
      y_q         <= 6'(c_START_Y);
      lives_q     <= 3'(c_NUM_LIVES);
      score_q     <= 7'd0;
      level_q     <= 4'd0;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      from_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      level_q     <= level_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
      from_over_q <= from_over_d;
    end
  end

  assign o_Frogger_X = x_q;
  assign o_Frogger_Y = y_q;
  assign o_Lives     = lives_q;
  assign o_Score     = score_q;
  assign o_Level     = level_q;
  assign o_State     = state_q;
  assign o_Hit       = hit_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed bench for frogger_game_ctrl: start, moves, clamps, car and water
// deaths, respawn, goal/win cycle, game over and mid-game reset.
module tb_frogger_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, game_start, up, down, left, right;
  logic [29:0] car_x, car_y, log_x, log_y;
  logic [3:0]  tile;
  logic [5:0]  fx, fy;
  logic [2:0]  lives;
  logic [6:0]  score;
  logic [3:0]  level;
  logic [2:0]  state;
  logic        hit;

  int n_assert = 0;
  int n_fail   = 0;

  frogger_game_ctrl dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Frame_Tick (frame_tick),
    .i_Game_Start (game_start),
    .i_Up_Mvt     (up),
    .i_Down_Mvt   (down),
    .i_Left_Mvt   (left),
    .i_Right_Mvt  (right),
    .i_Car_X      (car_x),
    .i_Car_Y      (car_y),
    .i_Log_X      (log_x),
    .i_Log_Y      (log_y),
    .i_Tile_Type  (tile),
    .o_Frogger_X  (fx),
    .o_Frogger_Y  (fy),
    .o_Lives      (lives),
    .o_Score      (score),
    .o_Level      (level),
    .o_State      (state),
    .o_Hit        (hit)
  );

  always #5 clk = ~clk;

  // Advance n clock edges, leaving time 1 unit past the last edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One press-and-release of the Up switch
  task automatic press_up();
    up = 1'b1; step(1);
    up = 1'b0; step(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1; step(1);
      frame_tick = 1'b0; step(1);
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; game_start = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    car_x = {5{6'd63}}; car_y = {5{6'd63}};
    log_x = {5{6'd63}}; log_y = {5{6'd63}};
    tile = 4'd3;
    step(2);
    rst = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_x", 32'(fx), 6);
    chk("rst_y", 32'(fy), 12);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_score", 32'(score), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_hit", 32'(hit), 0);

    // moves ignored in IDLE
    up = 1'b1; step(1); up = 1'b0; step(1);
    chk("idle_y", 32'(fy), 12);

    game_start = 1'b1; step(1);
    chk("start_state", 32'(state), 1);
    chk("start_x", 32'(fx), 6);
    chk("start_y", 32'(fy), 12);
    game_start = 1'b0;

    // down clamped at bottom row
    down = 1'b1; step(1); down = 1'b0; step(1);
    chk("down_clamp_y", 32'(fy), 12);

    // held Up gives one move; then Up+Left together: Up wins
    up = 1'b1; step(100); up = 1'b0; step(1);
    chk("hold_y", 32'(fy), 11);
    up = 1'b1; left = 1'b1; step(1);
    chk("prio_y", 32'(fy), 10);
    chk("prio_x", 32'(fx), 6);
    chk("prio_score", 32'(score), 2);
    up = 1'b0; left = 1'b0; step(1);
    chk("prio_x_after", 32'(fx), 6);

    // car 2 at (6,11), frog steps down into it
    car_x[17:12] = 6'd6; car_y[17:12] = 6'd11;
    down = 1'b1; step(1);
    chk("car_pos_y", 32'(fy), 11);
    chk("car_nohit_yet", 32'(hit), 0);
    step(1);
    chk("car_hit", 32'(hit), 1);
    chk("car_lives", 32'(lives), 2);
    chk("car_state", 32'(state), 2);
    down = 1'b0; step(1);
    chk("car_hit_pulse", 32'(hit), 0);
    car_x[17:12] = 6'd63; car_y[17:12] = 6'd63;
    press_up();
    chk("dying_move_y", 32'(fy), 11);
    chk("dying_score", 32'(score), 2);
    ticks(59);
    chk("dying_59_state", 32'(state), 2);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    chk("respawn_state", 32'(state), 1);
    chk("respawn_x", 32'(fx), 6);
    chk("respawn_y", 32'(fy), 12);

    // water with log 4 under the frog is safe; removing the log kills
    log_x[29:24] = 6'd6; log_y[29:24] = 6'd12; tile = 4'd2;
    step(2);
    chk("log_safe_hit", 32'(hit), 0);
    chk("log_safe_state", 32'(state), 1);
    log_x[29:24] = 6'd63; log_y[29:24] = 6'd63;
    step(1);
    chk("water_hit", 32'(hit), 1);
    chk("water_lives", 32'(lives), 1);
    chk("water_state", 32'(state), 2);
    tile = 4'd3;
    ticks(60);
    chk("respawn2_state", 32'(state), 1);

    // climb to goal row, then lily pad
    repeat (12) press_up();
    chk("climb_y", 32'(fy), 0);
    chk("climb_score", 32'(score), 14);
    chk("climb_state", 32'(state), 1);
    tile = 4'd4; step(1);
    chk("goal_score", 32'(score), 24);
    chk("goal_level", 32'(level), 1);
    chk("goal_state", 32'(state), 3);
    tile = 4'd3;
    ticks(119);
    chk("win_119_state", 32'(state), 3);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    chk("cleanup_state", 32'(state), 5);
    step(1);
    chk("post_win_state", 32'(state), 1);
    chk("post_win_x", 32'(fx), 6);
    chk("post_win_y", 32'(fy), 12);
    chk("post_win_score", 32'(score), 24);
    chk("post_win_level", 32'(level), 1);
    chk("post_win_lives", 32'(lives), 1);

    // climb again; Up clamped at top row; hit beats goal for the last life
    repeat (12) press_up();
    chk("climb2_score", 32'(score), 36);
    press_up();
    chk("up_clamp_y", 32'(fy), 0);
    chk("up_clamp_score", 32'(score), 36);
    tile = 4'd4; car_x[5:0] = 6'd6; car_y[5:0] = 6'd0;
    step(1);
    chk("over_hit", 32'(hit), 1);
    chk("over_lives", 32'(lives), 0);
    chk("over_state", 32'(state), 4);
    chk("over_score", 32'(score), 36);
    chk("over_level", 32'(level), 1);
    step(1);
    chk("over_hold_state", 32'(state), 4);
    chk("over_hold_hit", 32'(hit), 0);
    game_start = 1'b1; step(1);
    chk("over_cleanup", 32'(state), 5);
    game_start = 1'b0; step(1);
    chk("new_game_state", 32'(state), 0);
    chk("new_game_lives", 32'(lives), 3);
    chk("new_game_score", 32'(score), 0);
    chk("new_game_level", 32'(level), 0);
    chk("new_game_y", 32'(fy), 12);
    car_x[5:0] = 6'd63; car_y[5:0] = 6'd63; tile = 4'd3;

    // reset in the middle of DYING
    game_start = 1'b1; step(1); game_start = 1'b0;
    car_x[11:6] = 6'd6; car_y[11:6] = 6'd11;
    up = 1'b1; step(1); up = 1'b0; step(1);
    chk("mid_dying_state", 32'(state), 2);
    ticks(3);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_x", 32'(fx), 6);
    chk("mid_rst_y", 32'(fy), 12);
    chk("mid_rst_lives", 32'(lives), 3);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_hit", 32'(hit), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
